can_tx_bit_stuffer: RTL and testbench
=====================================

// Module: can_tx_bit_stuffer
// PURPOSE
// - Sits between can_transmitter and the bus driver. Takes the transmitter's tx_bit and inserts a complement
//   stuff bit after STUFF_LEN equal bits; holds the transmitter while doing so.
// - Monitors the bus (can_rx) at sample_point: flags arbitration loss and bit errors, then forces recessive.
// PARAMETERS
// - STUFF_LEN  5  equal-bit run length that triggers one stuff bit
// PORTS
// - clk                 in   1  system clock
// - rst                 in   1  asynchronous, active-high reset
// - sample_point        in   1  one-cycle strobe per bit time; all state updates only on this strobe
// - tx_bit              in   1  bit the transmitter presents this bit time
// - stuff_en            in   1  tx_bit lies in the stuffed region (SOF..last CRC bit)
// - arbitration_active  in   1  tx_bit is an arbitration bit (ID/RTR/IDE/SRR)
// - ack_slot            in   1  tx_bit is the ACK slot; mismatch is allowed
// - tx_done             in   1  transmitter finished the frame (IFS end)
// - can_rx              in   1  sampled bus level
// - can_tx              out  1  registered bus drive, 1 = recessive
// - tx_stall            out  1  combinational; gates the transmitter's sample_point (sample_point & ~tx_stall)
// - stuff_bit_out       out  1  the bit now on can_tx is a stuff bit
// - arb_lost            out  1  one-cycle pulse on arbitration loss
// - bit_err             out  1  one-cycle pulse on bit error
// - busy                out  1  state != IDLE
// BEHAVIOUR
// - Reset values: can_tx=1, all other outputs 0. State IDLE, run_cnt=0, all *_q flags cleared.
// - Latency: a tx_bit accepted at sample_point k drives can_tx during bit time k+1.
// - Registered context of the bit on the bus: last_q, win_q (stuff_en), arb_q, ack_q.
// - State IDLE
//   - At sample_point with stuff_en=1 (SOF): accept tx_bit, run_cnt=1, go to TX.
//   - Otherwise can_tx=1.
// - State TX: tx_stall = win_q && run_cnt==STUFF_LEN.
//   - At sample_point, monitor first: compare can_rx with can_tx.
//     - arb_q && !stuff_bit_out && can_tx=1 && can_rx=0: arb_lost pulse, go to LOST.
//     - Any other mismatch with ack_q=0: bit_err pulse, go to ERR.
//     - A stuff bit is never an arbitration bit; a mismatch on a stuff bit is a bit error.
//   - Then, if tx_stall: can_tx=~last_q, last_q=~last_q, run_cnt=1, stuff_bit_out=1.
//     - The stuff bit counts toward the next run. arb_q and ack_q are cleared; win_q is kept.
//   - Otherwise accept tx_bit, stuff_bit_out=0, and latch stuff_en/arbitration_active/ack_slot into win_q/arb_q/ack_q.
//     - If stuff_en: run_cnt = (tx_bit==last_q) ? run_cnt+1 : 1.
//     - Else run_cnt=0.
//   - The transition 1->0 on stuff_en still allows exactly one stuff bit after the last CRC bit, because
//     tx_stall uses win_q.
//   - tx_done at sample_point: go to IDLE, can_tx=1.
// - States LOST and ERR: can_tx=1, tx_stall=0, no monitoring. tx_done returns the block to IDLE.
// - Priority on one sample_point: rst > monitor result (LOST/ERR) > stuff insertion > normal accept.
//   - If a mismatch coincides with tx_stall=1, the stuff bit is not driven; can_tx goes to 1.
// - run_cnt saturates at STUFF_LEN, width $clog2(STUFF_LEN+1). It never exceeds STUFF_LEN in the stuffed region.
// - Reset mid-frame: immediate return to reset values. Bus goes recessive in the same cycle.
// - Edges of sample_point that arrive while tx_stall=1 are the only edges the transmitter misses.
// STRUCTURE
// - can_defs.svh: add typedef enum logic [1:0] {STUF_IDLE, STUF_TX, STUF_LOST, STUF_ERR} type_stuffer_states_e
//   and localparam CAN_STUFF_LEN = 5.
// - Single module; no sub-module. One always_ff for state/regs and one always_comb for next-state/tx_stall.
// TESTING
// - SOF + id_std=0x000: tx_bit=0 for 5 accepted bits.
//   -> 6th sample_point: tx_stall=1, can_tx=1, stuff_bit_out=1. Next bit (0) resumes with run_cnt=1.
// - id_std=0x555, rtr=0, dlc=1, data=0xAA (alternating).
//   -> No stuff bit in the arbitration field; can_tx equals tx_bit delayed by one bit time.
// - can_rx forced 0 while can_tx=1 on ID bit 7 with arb_q=1.
//   -> arb_lost pulses once, can_tx=1 until tx_done, then busy=0.
// - Last 5 CRC bits are 1 and stuff_en falls after them.
//   -> Exactly one stuff 0 is driven, CRC delimiter follows, no further stalls.
// - ack_slot with can_rx=0 -> no bit_err.
//   - can_rx inverted on DLC bit 2 -> bit_err pulse, state ERR, can_tx=1.
// - rst asserted mid-data-field with run_cnt=4 -> same cycle: can_tx=1, tx_stall=0, busy=0.
//   - Next SOF is stuffed from a fresh count.

Source files
------------

// File: rtl/can_tx_bit_stuffer_pkg.sv
// Shared definitions for the CAN transmit bit stuffer: state encoding and
// the default equal-bit run length that triggers a stuff bit.
package can_tx_bit_stuffer_pkg;

  typedef enum logic [1:0] {
    STUF_IDLE,
    STUF_TX,
    STUF_LOST,
    STUF_ERR
  } type_stuffer_states_e;

  localparam int CAN_STUFF_LEN = 5;

endpackage

// File: rtl/can_tx_bit_stuffer.sv
// CAN transmit bit stuffer: inserts a complement bit after STUFF_LEN equal bits,
// stalls the transmitter meanwhile, and watches the bus for arbitration loss / bit errors.
module can_tx_bit_stuffer
  import can_tx_bit_stuffer_pkg::*;
#(
  parameter int STUFF_LEN = CAN_STUFF_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_point,
  input  logic tx_bit,
  input  logic stuff_en,
  input  logic arbitration_active,
  input  logic ack_slot,
  input  logic tx_done,
  input  logic can_rx,
  output logic can_tx,
  output logic tx_stall,
  output logic stuff_bit_out,
  output logic arb_lost,
  output logic bit_err,
  output logic busy
);

  localparam int CNT_W = $clog2(STUFF_LEN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STUFF_LEN);

  type_stuffer_states_e state_q, state_d;
  logic [CNT_W-1:0]     run_cnt_q, run_cnt_d;
  logic                 last_q, last_d;
  logic                 win_q, win_d;
  logic                 arb_q, arb_d;
  logic                 ack_q, ack_d;
  logic                 can_tx_q, can_tx_d;
  logic                 stuff_q, stuff_d;
  logic                 arb_lost_q, arb_lost_d;
  logic                 bit_err_q, bit_err_d;

  logic mismatch;
  logic lost_hit;
  logic err_hit;

  // Stall uses win_q so the bit after the last stuffed-region bit can still be a stuff bit.
  always_comb begin
    tx_stall = (state_q == STUF_TX) && win_q && (run_cnt_q == RUN_MAX);
    mismatch = (can_rx != can_tx_q);
    lost_hit = mismatch && arb_q && !stuff_q && can_tx_q && !can_rx;
    err_hit  = mismatch && !lost_hit && !ack_q;

    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    last_d     = last_q;
    win_d      = win_q;
    arb_d      = arb_q;
    ack_d      = ack_q;
    can_tx_d   = can_tx_q;
    stuff_d    = stuff_q;
    arb_lost_d = 1'b0;
    bit_err_d  = 1'b0;

    case (state_q)
      STUF_IDLE: begin
        can_tx_d = 1'b1;
        stuff_d  = 1'b0;
        if (sample_point && stuff_en) begin
          can_tx_d  = tx_bit;
          last_d    = tx_bit;
          run_cnt_d = CNT_W'(1);
          win_d     = 1'b1;
          arb_d     = arbitration_active;
          ack_d     = ack_slot;
          state_d   = STUF_TX;
        end
      end

      STUF_TX: begin
        if (sample_point) begin
          // Monitor result wins over stuffing: a failed bit releases the bus at once.
          if (lost_hit || err_hit || tx_done) begin
            can_tx_d   = 1'b1;
            stuff_d    = 1'b0;
            run_cnt_d  = '0;
            win_d      = 1'b0;
            arb_d      = 1'b0;
            ack_d      = 1'b0;
            arb_lost_d = lost_hit;
            bit_err_d  = err_hit;
            if (lost_hit) begin
              state_d = STUF_LOST;
            end else if (err_hit) begin
              state_d = STUF_ERR;
            end else begin
              state_d = STUF_IDLE;
            end
          end else if (tx_stall) begin
            can_tx_d  = ~last_q;
            last_d    = ~last_q;
            run_cnt_d = CNT_W'(1);
            stuff_d   = 1'b1;
            arb_d     = 1'b0;
            ack_d     = 1'b0;
          end else begin
            can_tx_d = tx_bit;
            last_d   = tx_bit;
            stuff_d  = 1'b0;
            win_d    = stuff_en;
            arb_d    = arbitration_active;
            ack_d    = ack_slot;
            if (!stuff_en) begin
              run_cnt_d = '0;
            end else if (tx_bit != last_q) begin
              run_cnt_d = CNT_W'(1);
            end else if (run_cnt_q != RUN_MAX) begin
              run_cnt_d = run_cnt_q + 1'b1;
            end
          end
        end
      end

      STUF_LOST, STUF_ERR: begin
        can_tx_d = 1'b1;
        stuff_d  = 1'b0;
        if (sample_point && tx_done) begin
          state_d = STUF_IDLE;
        end
      end

      default: begin
        state_d  = STUF_IDLE;
        can_tx_d = 1'b1;
        stuff_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= STUF_IDLE;
      run_cnt_q  <= '0;
      last_q     <= 1'b0;
      win_q      <= 1'b0;
      arb_q      <= 1'b0;
      ack_q      <= 1'b0;
      can_tx_q   <= 1'b1;
      stuff_q    <= 1'b0;
      arb_lost_q <= 1'b0;
      bit_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      last_q     <= last_d;
      win_q      <= win_d;
      arb_q      <= arb_d;
      ack_q      <= ack_d;
      can_tx_q   <= can_tx_d;
      stuff_q    <= stuff_d;
      arb_lost_q <= arb_lost_d;
      bit_err_q  <= bit_err_d;
    end
  end

  assign can_tx        = can_tx_q;
  assign stuff_bit_out = stuff_q;
  assign arb_lost      = arb_lost_q;
  assign bit_err       = bit_err_q;
  assign busy          = (state_q != STUF_IDLE);

endmodule

// File: tb/tb_can_tx_bit_stuffer.sv
// Directed, table-driven bench for can_tx_bit_stuffer with hand-computed
// expectations per bit time, plus a hand-written mid-frame reset sequence.
module tb_can_tx_bit_stuffer;

   localparam logic [1:0] ECHO  = 2'd0;
   localparam logic [1:0] RX_0  = 2'd2;
   localparam logic [1:0] RX_1  = 2'd3;

   typedef struct {
      string      name;
      logic       txBit;
      logic       stuffEn;
      logic       arb;
      logic       ack;
      logic       done;
      logic [1:0] rxMode;
      logic       expTx;
      logic       expStuff;
      logic       expStall;
      logic       expArb;
      logic       expErr;
      logic       expBusy;
   } vec_t;

   logic clk;
   logic rst;
   logic samplePoint;
   logic txBit;
   logic stuffEn;
   logic arbActive;
   logic ackSlot;
   logic txDone;
   logic canRx;
   logic canTx;
   logic txStall;
   logic stuffBitOut;
   logic arbLost;
   logic bitErr;
   logic busy;

   int   checks;
   int   errors;
   vec_t vecs[$];

   can_tx_bit_stuffer dut (
      .clk                (clk),
      .rst                (rst),
      .sample_point       (samplePoint),
      .tx_bit             (txBit),
      .stuff_en           (stuffEn),
      .arbitration_active (arbActive),
      .ack_slot           (ackSlot),
      .tx_done            (txDone),
      .can_rx             (canRx),
      .can_tx             (canTx),
      .tx_stall           (txStall),
      .stuff_bit_out      (stuffBitOut),
      .arb_lost           (arbLost),
      .bit_err            (bitErr),
      .busy               (busy)
   );

   // Free-running 10-time-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it and reports a FAIL line on disagreement
   task automatic checkOutput(input string name, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0b expected %0b", name, actual, expected);
      end
   endtask

   // Queue one bit-time record with its hand-computed expected outputs
   task automatic addVec(input string name, input logic tb, input logic en, input logic arb,
                         input logic ack, input logic done, input logic [1:0] rx,
                         input logic eTx, input logic eStuff, input logic eStall,
                         input logic eArb, input logic eErr, input logic eBusy);
      vec_t v;
      v.name = name; v.txBit = tb; v.stuffEn = en; v.arb = arb; v.ack = ack; v.done = done;
      v.rxMode = rx; v.expTx = eTx; v.expStuff = eStuff; v.expStall = eStall;
      v.expArb = eArb; v.expErr = eErr; v.expBusy = eBusy;
      vecs.push_back(v);
   endtask

   // Drive one sample_point strobe from a negedge, check #1 after the edge, then confirm pulses drop
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      txBit     = v.txBit;
      stuffEn   = v.stuffEn;
      arbActive = v.arb;
      ackSlot   = v.ack;
      txDone    = v.done;
      canRx     = (v.rxMode == ECHO) ? canTx : v.rxMode[0];
      samplePoint = 1'b1;
      @(posedge clk);
      #1;
      samplePoint = 1'b0;
      checkOutput({v.name, ".can_tx"},        canTx,       v.expTx);
      checkOutput({v.name, ".stuff_bit_out"}, stuffBitOut, v.expStuff);
      checkOutput({v.name, ".tx_stall"},      txStall,     v.expStall);
      checkOutput({v.name, ".arb_lost"},      arbLost,     v.expArb);
      checkOutput({v.name, ".bit_err"},       bitErr,      v.expErr);
      checkOutput({v.name, ".busy"},          busy,        v.expBusy);
      @(posedge clk);
      #1;
      checkOutput({v.name, ".pulse_end"},     arbLost | bitErr, 1'b0);
   endtask

   // Main sequence: reset checks, vector table, then the reset-mid-frame sequence
   initial begin
      logic [10:0] idB;
      vec_t        hv;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      samplePoint = 1'b0;
      txBit = 1'b1; stuffEn = 1'b0; arbActive = 1'b0; ackSlot = 1'b0; txDone = 1'b0; canRx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset.can_tx",        canTx,       1'b1);
      checkOutput("reset.tx_stall",      txStall,     1'b0);
      checkOutput("reset.stuff_bit_out", stuffBitOut, 1'b0);
      checkOutput("reset.arb_lost",      arbLost,     1'b0);
      checkOutput("reset.bit_err",       bitErr,      1'b0);
      checkOutput("reset.busy",          busy,        1'b0);
      @(negedge clk);
      rst = 1'b0;

      // A: SOF + ID 0x000, two stuff bits inserted and then tx_done
      addVec("A_sof", 0,1,0,0,0,ECHO, 0,0,0,0,0,1);
      for (int i = 0; i < 3; i++) addVec("A_id", 0,1,1,0,0,ECHO, 0,0,0,0,0,1);
      addVec("A_run5",  0,1,1,0,0,ECHO, 0,0,1,0,0,1);
      addVec("A_stuf1", 0,1,1,0,0,ECHO, 1,1,0,0,0,1);
      for (int i = 0; i < 4; i++) addVec("A_resume", 0,1,1,0,0,ECHO, 0,0,0,0,0,1);
      addVec("A_run5b", 0,1,1,0,0,ECHO, 0,0,1,0,0,1);
      addVec("A_stuf2", 0,1,1,0,0,ECHO, 1,1,0,0,0,1);
      addVec("A_done",  1,0,0,0,1,ECHO, 1,0,0,0,0,0);

      // B: alternating ID 0x555 + RTR=0, bus mirrors tx_bit with no stalls
      idB = 11'h555;
      addVec("B_sof", 0,1,0,0,0,ECHO, 0,0,0,0,0,1);
      for (int i = 10; i >= 0; i--) addVec("B_id", idB[i],1,1,0,0,ECHO, idB[i],0,0,0,0,1);
      addVec("B_rtr",  0,1,1,0,0,ECHO, 0,0,0,0,0,1);
      addVec("B_done", 1,0,0,0,1,ECHO, 1,0,0,0,0,0);

      // C: ID 0x0AA, bus dominant while ID bit 7 (recessive) is on the wire
      addVec("C_sof", 0,1,0,0,0,ECHO, 0,0,0,0,0,1);
      for (int i = 0; i < 3; i++) addVec("C_id", 0,1,1,0,0,ECHO, 0,0,0,0,0,1);
      addVec("C_id7",  1,1,1,0,0,ECHO, 1,0,0,0,0,1);
      addVec("C_lost", 0,1,1,0,0,RX_0, 1,0,0,1,0,1);
      addVec("C_hold", 1,1,1,0,0,RX_0, 1,0,0,0,0,1);
      addVec("C_done", 1,0,0,0,1,ECHO, 1,0,0,0,0,0);

      // D: last five CRC bits 1, stuff_en drops, one stuff 0 then delimiter, ACK overridden by bus
      addVec("D_sof", 0,1,0,0,0,ECHO, 0,0,0,0,0,1);
      for (int i = 0; i < 4; i++) addVec("D_crc", 1,1,0,0,0,ECHO, 1,0,0,0,0,1);
      addVec("D_crc5",   1,1,0,0,0,ECHO, 1,0,1,0,0,1);
      addVec("D_stuf",   1,0,0,0,0,ECHO, 0,1,0,0,0,1);
      addVec("D_delim",  1,0,0,0,0,ECHO, 1,0,0,0,0,1);
      addVec("D_ack",    1,0,0,1,0,ECHO, 1,0,0,0,0,1);
      addVec("D_ackdel", 1,0,0,0,0,RX_0, 1,0,0,0,0,1);
      for (int i = 0; i < 6; i++) addVec("D_eof", 1,0,0,0,0,ECHO, 1,0,0,0,0,1);
      addVec("D_done",   1,0,0,0,1,ECHO, 1,0,0,0,0,0);

      // E1: recessive data bit read back dominant outside arbitration -> bit error
      addVec("E1_sof", 0,1,0,0,0,ECHO, 0,0,0,0,0,1);
      addVec("E1_b1",  1,1,0,0,0,ECHO, 1,0,0,0,0,1);
      addVec("E1_err", 0,1,0,0,0,RX_0, 1,0,0,0,1,1);
      addVec("E1_hold",0,1,0,0,0,RX_0, 1,0,0,0,0,1);
      addVec("E1_done",1,0,0,0,1,ECHO, 1,0,0,0,0,0);

      // E2: mismatch on a recessive stuff bit during arbitration is a bit error, not a loss
      addVec("E2_sof", 0,1,0,0,0,ECHO, 0,0,0,0,0,1);
      for (int i = 0; i < 3; i++) addVec("E2_id", 0,1,1,0,0,ECHO, 0,0,0,0,0,1);
      addVec("E2_run5", 0,1,1,0,0,ECHO, 0,0,1,0,0,1);
      addVec("E2_stuf", 0,1,1,0,0,ECHO, 1,1,0,0,0,1);
      addVec("E2_err",  0,1,1,0,0,RX_0, 1,0,0,0,1,1);
      addVec("E2_done", 1,0,0,0,1,ECHO, 1,0,0,0,0,0);

      // E3: mismatch on the strobe where a stuff bit is due -> no stuff, bus recessive
      addVec("E3_sof", 0,1,0,0,0,ECHO, 0,0,0,0,0,1);
      for (int i = 0; i < 3; i++) addVec("E3_d", 0,1,0,0,0,ECHO, 0,0,0,0,0,1);
      addVec("E3_run5", 0,1,0,0,0,ECHO, 0,0,1,0,0,1);
      addVec("E3_err",  0,1,0,0,0,RX_1, 1,0,0,0,1,1);
      addVec("E3_done", 1,0,0,0,1,ECHO, 1,0,0,0,0,0);

      foreach (vecs[i]) applyStimulus(vecs[i]);

      // F: reset with run_cnt=4 mid-data, then a fresh frame stuffs after five bits
      hv = '{name:"F_sof", txBit:0, stuffEn:1, arb:0, ack:0, done:0, rxMode:ECHO,
             expTx:0, expStuff:0, expStall:0, expArb:0, expErr:0, expBusy:1};
      applyStimulus(hv);
      hv.name = "F_b1"; hv.txBit = 1; hv.expTx = 1;
      applyStimulus(hv);
      hv.name = "F_run"; hv.txBit = 0; hv.expTx = 0;
      for (int i = 0; i < 4; i++) applyStimulus(hv);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("F_rst.can_tx",        canTx,       1'b1);
      checkOutput("F_rst.tx_stall",      txStall,     1'b0);
      checkOutput("F_rst.busy",          busy,        1'b0);
      checkOutput("F_rst.stuff_bit_out", stuffBitOut, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      hv.name = "F2_sof";
      applyStimulus(hv);
      hv.name = "F2_run";
      for (int i = 0; i < 3; i++) applyStimulus(hv);
      hv.name = "F2_run5"; hv.expStall = 1;
      applyStimulus(hv);
      hv.name = "F2_stuf"; hv.expTx = 1; hv.expStuff = 1; hv.expStall = 0;
      applyStimulus(hv);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
